// File: rtl/opb_regbank_pkg.sv
// ============================================================================
// Module   : opb_regbank_pkg
// Purpose  : Shared constants, word-map helpers and handshake state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package opb_regbank_pkg;

    localparam int STATUS_UPD_LSB  = 0;
    localparam int STATUS_OVR_LSB  = 16;
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int MAX_REGS        = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } opb_state_e;

    function automatic int STATUS_WORD(input int n);
        return n;
    endfunction

    function automatic int CTRL_WORD(input int n);
        return n + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/opb_regbank_decode.sv
// ============================================================================
// Module   : opb_regbank_decode
// Purpose  : OPB window decode, word index and single-cycle ack handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module opb_regbank_decode
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_select,
    input  logic        i_rnw,
    input  logic [31:0] i_abus,
    output logic        o_rd_stb,
    output logic        o_wr_stb,
    output logic [29:0] o_word,
    output logic        o_ack
);

    opb_state_e  state_q;
    opb_state_e  state_d;
    logic [32:0] w_off;
    logic [32:0] w_top;
    logic        w_hit;
    logic        unused_bits;

    // Borrow bits give the range check without constant-folding compares on a zero base.
    assign w_off  = {1'b0, i_abus} - {1'b0, C_BASEADDR};
    assign w_top  = {1'b0, C_HIGHADDR} - {1'b0, i_abus};
    assign w_hit  = i_select & ~w_off[32] & ~w_top[32];
    assign o_word = w_off[31:2];
    assign unused_bits = ^{w_off[1:0], w_top[31:0]};

    assign o_ack    = (state_q == ACK);
    assign o_rd_stb = (state_q == IDLE) & w_hit & i_rnw;
    assign o_wr_stb = (state_q == IDLE) & w_hit & ~i_rnw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_hit && !o_ack) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

endmodule

`default_nettype wire

// File: rtl/opb_register_bank_simulink2ppc.sv
// ============================================================================
// Module   : opb_register_bank_simulink2ppc
// Purpose  : NUM_REGS user capture registers with sticky status and freeze,
//            read over OPB. Optional: OPB_REGBANK_COHERENT_SNAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module opb_register_bank_simulink2ppc
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          NUM_REGS     = 4,
    parameter int          DATA_WIDTH   = 32
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst,
    output logic [0:31]                    Sl_DBus,
    output logic                           Sl_errAck,
    output logic                           Sl_retry,
    output logic                           Sl_toutSup,
    output logic                           Sl_xferAck,
    input  logic [0:31]                    OPB_ABus,
    input  logic [0:3]                     OPB_BE,
    input  logic [0:31]                    OPB_DBus,
    input  logic                           OPB_RNW,
    input  logic                           OPB_select,
    input  logic                           OPB_seqAddr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] user_data_in,
    input  logic [NUM_REGS-1:0]            user_valid,
    output logic                           user_frozen
);

    logic                  dec_rd_stb;
    logic                  dec_wr_stb;
    logic                  dec_ack;
    logic [29:0]           dec_word;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];
    logic [NUM_REGS-1:0]   upd_q, upd_d, ovr_q, ovr_d;
    logic [NUM_REGS-1:0]   cap, upd_kept;
    logic                  freeze_q, freeze_d;
    logic                  stat_rd_q, stat_rd_d;
    logic                  ctrl_wr_q, ctrl_wr_d;
    logic                  ctrl_wval_q, ctrl_wval_d;
    logic [31:0]           dbus_q, dbus_d, rdata;
    logic                  unused_ok;

    opb_regbank_decode #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_decode (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .i_select (OPB_select),
        .i_rnw    (OPB_RNW),
        .i_abus   (OPB_ABus),
        .o_rd_stb (dec_rd_stb),
        .o_wr_stb (dec_wr_stb),
        .o_word   (dec_word),
        .o_ack    (dec_ack)
    );

`ifdef OPB_REGBANK_COHERENT_SNAP_EN
    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_REGS];

    always_comb begin
        shadow_d = shadow_q;
        if (dec_rd_stb && dec_word == 30'd0) shadow_d = regs_q;
        rd_src    = shadow_q;
        rd_src[0] = regs_q[0];
    end

    always_ff @(posedge OPB_Clk) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OPB_Rst) shadow_q[k] <= '0;
            else         shadow_q[k] <= shadow_d[k];
        end
    end
`else
    always_comb rd_src = regs_q;
`endif

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (dec_word == 30'(k)) rdata = 32'(rd_src[k]);
        end
        if (dec_word == 30'(STATUS_WORD(NUM_REGS))) begin
            rdata[STATUS_UPD_LSB +: NUM_REGS] = upd_q;
            rdata[STATUS_OVR_LSB +: NUM_REGS] = ovr_q;
        end
        if (dec_word == 30'(CTRL_WORD(NUM_REGS))) rdata[CTRL_FREEZE_BIT] = freeze_q;
    end

    always_comb begin
        regs_d = regs_q;
        cap    = user_valid & {NUM_REGS{~freeze_q}};
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cap[k]) regs_d[k] = user_data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
        // Clear is applied before capture so a same-cycle capture survives without flagging overrun.
        upd_kept = upd_q & ~{NUM_REGS{dec_ack & stat_rd_q}};
        upd_d    = upd_kept | cap;
        ovr_d    = (ovr_q & ~{NUM_REGS{dec_ack & stat_rd_q}}) | (cap & upd_kept);

        freeze_d = freeze_q;
        if (dec_ack && ctrl_wr_q) freeze_d = ctrl_wval_q;

        stat_rd_d   = dec_rd_stb & (dec_word == 30'(STATUS_WORD(NUM_REGS)));
        ctrl_wr_d   = dec_wr_stb & (dec_word == 30'(CTRL_WORD(NUM_REGS))) & OPB_BE[3];
        ctrl_wval_d = OPB_DBus[31];
        dbus_d      = dec_rd_stb ? rdata : 32'd0;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            upd_q       <= '0;
            ovr_q       <= '0;
            freeze_q    <= 1'b0;
            stat_rd_q   <= 1'b0;
            ctrl_wr_q   <= 1'b0;
            ctrl_wval_q <= 1'b0;
            dbus_q      <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
            upd_q       <= upd_d;
            ovr_q       <= ovr_d;
            freeze_q    <= freeze_d;
            stat_rd_q   <= stat_rd_d;
            ctrl_wr_q   <= ctrl_wr_d;
            ctrl_wval_q <= ctrl_wval_d;
            dbus_q      <= dbus_d;
        end
    end

    assign Sl_DBus     = dbus_q;
    assign Sl_xferAck  = dec_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = freeze_q;

    assign unused_ok = ^{OPB_seqAddr, OPB_DBus[0:30], OPB_BE[0:2],
                         C_FAMILY[0], C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

endmodule

`default_nettype wire

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// ============================================================================
// Module   : tb_opb_register_bank_simulink2ppc
// Purpose  : Self-checking bench for the OPB capture register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] C_BASE = 32'h0000_1000;
    localparam logic [31:0] C_HIGH = 32'h0000_10FF;
    localparam int          NR     = 4;
    localparam int          DW     = 32;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_CAP = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [0:31]       Sl_DBus;
    logic              Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
    logic [0:31]       OPB_ABus = '0;
    logic [0:3]        OPB_BE = '0;
    logic [0:31]       OPB_DBus = '0;
    logic              OPB_RNW = 1'b0;
    logic              OPB_select = 1'b0;
    logic              OPB_seqAddr = 1'b0;
    logic [NR*DW-1:0]  user_data_in = '0;
    logic [NR-1:0]     user_valid = '0;
    logic              user_frozen;

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR (C_BASE),
        .C_HIGHADDR (C_HIGH),
        .NUM_REGS   (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .Sl_DBus      (Sl_DBus),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .Sl_xferAck   (Sl_xferAck),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_frozen  (user_frozen)
    );

    typedef struct {
        int          kind;
        logic [31:0] off;
        logic [3:0]  be;
        logic [31:0] data;
        logic [NR-1:0] mask;
        logic [31:0] exp;
        logic        exp_frozen;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic void add(input int kind, input logic [31:0] off, input logic [3:0] be,
                                input logic [31:0] data, input logic [NR-1:0] mask,
                                input logic [31:0] exp, input logic exp_frozen);
        vec_t v;
        v.kind = kind; v.off = off; v.be = be; v.data = data;
        v.mask = mask; v.exp = exp; v.exp_frozen = exp_frozen;
        vecs.push_back(v);
    endfunction

    task automatic drive_user(input logic [NR-1:0] mask, input logic [31:0] data);
        for (int k = 0; k < NR; k++) user_data_in[k*DW +: DW] = data;
        user_valid = mask;
    endtask

    task automatic capture(input logic [NR-1:0] mask, input logic [31:0] data);
        @(posedge clk); #1;
        drive_user(mask, data);
        @(posedge clk); #1;
        user_valid = '0;
    endtask

    // Reads pop their expectation from exp_q when the ack arrives; a capture can be fired inside the ack cycle.
    task automatic bus_xfer(input bit rnw, input logic [31:0] off, input logic [3:0] be,
                            input logic [31:0] wdata, input bit expect_ack,
                            input logic [NR-1:0] cap_mask, input logic [31:0] cap_data);
        int lat;
        bit got;
        @(posedge clk); #1;
        OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = C_BASE + off;
        OPB_BE = be; OPB_DBus = wdata;
        got = 1'b0; lat = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                got = 1'b1; lat = c;
            end else begin
                check("dbus_zero_without_ack", Sl_DBus, 32'd0);
            end
        end
        if (expect_ack) begin
            check("ack_seen", 32'(got), 32'd1);
            if (got) begin
                check("ack_latency", 32'(lat), 32'd1);
                check("tie_offs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
                if (rnw && exp_q.size() > 0) check("read_data", Sl_DBus, exp_q.pop_front());
                if (cap_mask != '0) drive_user(cap_mask, cap_data);
            end else if (rnw && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end else begin
            check("no_ack_outside_window", 32'(got), 32'd0);
        end
        @(posedge clk); #1;
        OPB_select = 1'b0;
        user_valid = '0;
        @(negedge clk);
        check("ack_single_cycle", 32'(Sl_xferAck), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acks;

        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_CAP, 0, 0, 32'hDEADBEEF, 4'b0100, 0, 1'b0);
        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_RD,  32'h08, 4'hF, 0, '0, 32'hDEADBEEF, 1'b0);
        add(K_RD,  32'h10, 4'hF, 0, '0, 32'h0000_0004, 1'b0);
        add(K_RD,  32'h10, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_CAP, 0, 0, 32'h1, 4'b0010, 0, 1'b0);
        add(K_CAP, 0, 0, 32'h2, 4'b0010, 0, 1'b0);
        add(K_RD,  32'h10, 4'hF, 0, '0, 32'h0002_0002, 1'b0);
        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_RD,  32'h04, 4'hF, 0, '0, 32'h2, 1'b0);
        add(K_WR,  32'h14, 4'b0001, 32'h1, '0, 0, 1'b1);
        add(K_RD,  32'h14, 4'hF, 0, '0, 32'h1, 1'b1);
        add(K_CAP, 0, 0, 32'h55, 4'b0001, 0, 1'b1);
        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h0, 1'b1);
        add(K_RD,  32'h10, 4'hF, 0, '0, 32'h0, 1'b1);
        add(K_WR,  32'h14, 4'b1110, 32'h0, '0, 0, 1'b1);
        add(K_RD,  32'h14, 4'hF, 0, '0, 32'h1, 1'b1);
        add(K_WR,  32'h14, 4'b1111, 32'h0, '0, 0, 1'b0);
        add(K_CAP, 0, 0, 32'h55, 4'b0001, 0, 1'b0);
        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h55, 1'b0);
        add(K_RD,  32'h10, 4'hF, 0, '0, 32'h0000_0001, 1'b0);
        add(K_RD,  32'hFC, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_WR,  32'h18, 4'hF, 32'hFFFF_FFFF, '0, 0, 1'b0);
        add(K_RD,  32'h18, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_RD,  32'h14, 4'hF, 0, '0, 32'h0, 1'b0);
        add(K_RD,  32'h00, 4'hF, 0, '0, 32'h55, 1'b0);
        add(K_CAP, 0, 0, 32'h11, 4'b0010, 0, 1'b0);
`ifdef OPB_REGBANK_COHERENT_SNAP_EN
        add(K_RD,  32'h04, 4'hF, 0, '0, 32'h2, 1'b0);
`else
        add(K_RD,  32'h04, 4'hF, 0, '0, 32'h11, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_xferack", 32'(Sl_xferAck), 32'd0);
        check("reset_dbus", Sl_DBus, 32'd0);
        check("reset_frozen", 32'(user_frozen), 32'd0);
        check("reset_tie_offs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_RD: begin
                    exp_q.push_back(vecs[i].exp);
                    bus_xfer(1'b1, vecs[i].off, vecs[i].be, 0, 1'b1, '0, 0);
                end
                K_WR:    bus_xfer(1'b0, vecs[i].off, vecs[i].be, vecs[i].data, 1'b1, '0, 0);
                default: capture(vecs[i].mask, vecs[i].data);
            endcase
            check($sformatf("frozen_after_vec%0d", i), 32'(user_frozen), 32'(vecs[i].exp_frozen));
        end

        // Capture on reg 1 inside the STATUS-read ack cycle must survive the clear.
        capture(4'b0010, 32'h22);
        exp_q.push_back(32'h0002_0002);
        bus_xfer(1'b1, 32'h10, 4'hF, 0, 1'b1, 4'b0010, 32'h77);
        exp_q.push_back(32'h0000_0002);
        bus_xfer(1'b1, 32'h10, 4'hF, 0, 1'b1, '0, 0);
        exp_q.push_back(32'h55);
        bus_xfer(1'b1, 32'h00, 4'hF, 0, 1'b1, '0, 0);
        exp_q.push_back(32'h77);
        bus_xfer(1'b1, 32'h04, 4'hF, 0, 1'b1, '0, 0);

        // Addresses just outside the window must never be acked.
        bus_xfer(1'b1, 32'h100, 4'hF, 0, 1'b0, '0, 0);
        bus_xfer(1'b1, 32'hFFFF_FFFC, 4'hF, 0, 1'b0, '0, 0);

        // Reset in the select cycle: no ack, and state returns to zero.
        bus_xfer(1'b0, 32'h14, 4'hF, 32'h1, 1'b1, '0, 0);
        check("frozen_before_reset", 32'(user_frozen), 32'd1);
        @(posedge clk); #1;
        OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = C_BASE; rst = 1'b1;
        @(posedge clk); #1;
        OPB_select = 1'b0; rst = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (Sl_xferAck) acks++;
        end
        check("reset_mid_transfer_no_ack", 32'(acks), 32'd0);
        check("frozen_after_reset", 32'(user_frozen), 32'd0);
        exp_q.push_back(32'h0);
        bus_xfer(1'b1, 32'h10, 4'hF, 0, 1'b1, '0, 0);
        exp_q.push_back(32'h0);
        bus_xfer(1'b1, 32'h00, 4'hF, 0, 1'b1, '0, 0);
        exp_q.push_back(32'h0);
        bus_xfer(1'b1, 32'h08, 4'hF, 0, 1'b1, '0, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/opb_register_bank_simulink2ppc.md
Name: opb_register_bank_simulink2ppc

Overview:
- Parametrised successor to the single-register Simulink-to-PPC OPB slave: NUM_REGS user-side capture registers, read by the PowerPC over OPB.
- Adds per-register capture strobes, sticky update/overrun flags with read-to-clear, and a software freeze control.
- Sits in the XPS ROACH base system on the OPB bus. A system-level wrapper instantiates it per yellow-block.

Parameters:
- C_BASEADDR, 32'h00000000: OPB base address; must be aligned to the window size.
- C_HIGHADDR, 32'h000000FF: OPB high address (inclusive).
- C_OPB_AWIDTH, 32: OPB address width. Only 32 is supported.
- C_OPB_DWIDTH, 32: OPB data width. Only 32 is supported.
- C_FAMILY, "virtex5": target family. Passed through only; no behavioural effect.
- NUM_REGS, 4: number of capture registers, 1..16.
- DATA_WIDTH, 32: valid bits per register, 1..32. Values are zero-extended to 32 on read.

Ports:
- OPB_Clk  in  1  the only clock; both OPB and user logic run on it.
- OPB_Rst  in  1  synchronous, active-high reset.
- Sl_DBus  out  [0:31]  read data; 0 whenever Sl_xferAck=0.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects OPB bits 0:7 (MSB byte).
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  bus cycle active.
- OPB_seqAddr  in  1  ignored.
- user_data_in  in  [NUM_REGS*DATA_WIDTH-1:0]  register k occupies slice k*DATA_WIDTH +: DATA_WIDTH.
- user_valid  in  [NUM_REGS-1:0]  per-register capture strobe.
- user_frozen  out  1  current freeze bit, for the Simulink side.

Behaviour:
- Clock and reset: one clock, OPB_Clk. Reset is OPB_Rst, synchronous and active-high.
- Reset values: all registers, flags, control, Sl_xferAck, Sl_DBus and user_frozen are 0.
- Reset asserted mid-transfer: no ack is issued. The master retries after reset.
- Decode:
  - hit = OPB_select & (C_BASEADDR <= ABus <= C_HIGHADDR).
  - word = (ABus - C_BASEADDR) >> 2.
- Word map:
  - word 0..NUM_REGS-1: capture registers, read-only.
  - word NUM_REGS: STATUS. Bits [NUM_REGS-1:0] = updated; bits [16+NUM_REGS-1:16] = overrun. Read-to-clear.
  - word NUM_REGS+1: CONTROL. Bit 0 = freeze; read/write.
  - any other word in the window: reads return 0; writes are acked and ignored.
- Bit mapping: numeric values are preserved. User bit 31 corresponds to OPB bit 0.
- Handshake FSM:
  - IDLE -> ACK when hit & ~Sl_xferAck.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck is high exactly one cycle, one cycle after the hit is sampled.
  - Sl_DBus is valid only in ACK.
  - Back-to-back selects are acked every second cycle.
  - If select drops during ACK, the ack is still issued and the master discards it.
- Read data: registered at the IDLE->ACK transition from the values present in that cycle.
- Control writes: byte-lane masked by BE. A write with BE[3]=0 leaves bit 0 (LSB byte) unchanged. Writes commit in the ACK cycle.
- Capture:
  - If user_valid[k] & ~freeze: reg[k] <= slice k.
  - updated[k] <= 1.
  - overrun[k] <= 1 if updated[k] was already 1.
- Status clear:
  - Applies to both updated and overrun, on the ACK cycle of a STATUS read.
  - A capture in the same cycle wins: its set bits stay 1.
  - The read returns the pre-clear value.
- Freeze: while freeze=1, user_valid is ignored entirely. Registers and flags hold.
- user_frozen = freeze bit, registered, with no extra latency beyond the control write commit.

Optional Feature:
- Macro: OPB_REGBANK_COHERENT_SNAP_EN.
- Defined:
  - A read of word 0 also copies all NUM_REGS live registers into shadow registers, in the same cycle its data is latched.
  - Reads of words 1..NUM_REGS-1 return shadow values.
  - This gives a coherent multi-word read.
- Undefined: all reads return live registers; no shadow storage is generated.

Decomposition:
- Package opb_regbank_pkg:
  - STATUS_UPD_LSB=0, STATUS_OVR_LSB=16, CTRL_FREEZE_BIT=0, MAX_REGS=16.
  - Word-offset functions STATUS_WORD(n)=n and CTRL_WORD(n)=n+1.
  - FSM state typedef {IDLE, ACK}.
- Sub-module opb_regbank_decode: address range check, word index and the ack FSM. Outputs rd_stb, wr_stb, word and a one-cycle ack.
- Top level holds the storage, flags, control and read mux.

Test Plan:
- Reset, then read word 0 at C_BASEADDR -> Sl_xferAck exactly 1 cycle after select; Sl_DBus=0; errAck, retry and toutSup stay 0.
- user_valid[2]=1 with slice 2=32'hDEADBEEF, then read word 2 -> 32'hDEADBEEF. STATUS read -> 32'h00000004; second STATUS read -> 0.
- Pulse user_valid[1] twice with no read between -> STATUS = 32'h00020002. A capture on reg 1 in the same cycle as the STATUS-read ack -> next STATUS read = 32'h00000002.
- Write CONTROL=1 with BE=4'b0001 -> user_frozen=1 and captures ignored. Write with BE=4'b1110 -> freeze remains 1. Write 0 with BE=4'b1111 -> captures resume.
- Read address C_HIGHADDR-3 (unmapped word) -> acked, data 0. Assert OPB_Rst during the select cycle -> no ack.
- With OPB_REGBANK_COHERENT_SNAP_EN defined: read word 0, capture new reg 1 value 32'h11, read word 1 -> old value. Without the macro -> 32'h11.
